multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle main control unit. It is a Moore/Mealy FSM that sequences the shared-ALU, shared-memory MIPS datapath over 3–5+ cycles per instruction. It stalls on a memory-ready handshake, optionally supports immediate-ALU ops and BNE, and counts retired instructions. It sits between the instruction register (opcode field) and the datapath multiplexers and enables.

## Interface
Parameters:
- ENABLE_IMM, 1, decode ADDI/ANDI/ORI/SLTI; when 0 these are illegal
- ENABLE_BNE, 1, decode BNE; when 0 it is illegal
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB, ALUOp, PCSource  out  2 each  datapath mux/ALU selects
- state  out  4  current state encoding
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

## Operation
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, ADDI=001000, ANDI=001100, ORI=001101, SLTI=001010.
- Outputs decode from state_q. Any signal not listed for a state is 0.
- **FETCH (0):** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready (Mealy). Stay while mem_ready=0; go to DECODE when it is 1.
- **DECODE (1):** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target). Next state by opcode:
  - LW/SW → MEMADR
  - R → EXEC
  - BEQ/BNE → BRANCH
  - J → JUMP
  - imm → IMMEX
  - other → FETCH with illegal_op=1
- **MEMADR (2):** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD (LW) or MEMWR (SW).
- **MEMRD (3):** IorD=1, MemRead=1. Hold until mem_ready, then go to MEMWB.
- **MEMWB (4):** RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
- **MEMWR (5):** IorD=1, MemWrite=1. Hold until mem_ready, then go to FETCH.
- **EXEC (6):** ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- **ALUWB (7):** RegDst=1, RegWrite=1. Go to FETCH.
- **BRANCH (8):** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNE=(opcode==BNE). Go to FETCH.
- **JUMP (9):** PCWrite=1, PCSource=10. Go to FETCH.
- **IMMEX (10):** ALUSrcA=1, ALUSrcB=10, ALUOp=11 (ALU decoder resolves via opcode). Go to IMMWB.
- **IMMWB (11):** RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
- Encodings 12–15 are unreachable; they decode as all-zero outputs and go to FETCH.
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWR (when ready), ALUWB, BRANCH, JUMP, or IMMWB. Illegal opcodes do not count.

## Timing
- **Reset** (sampled at the edge): state_q=FETCH, retired=0. While reset=1, all write/strobe outputs are forced to 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite. Selects show FETCH values and illegal_op=0.
- **Reset mid-instruction:** aborts immediately with no further writes. The first fetch is issued the cycle after reset drops.
- **Latency with mem_ready held 1:** R/IMM=4, LW=5, SW=4, BEQ/BNE=3, J=3, illegal=2 cycles, each returning to FETCH. Each 0-cycle of mem_ready in FETCH, MEMRD, or MEMWR adds exactly one cycle.
- **mem_ready outside memory states:** ignored.
- **illegal_op:** high only in the DECODE cycle.
- **Counter:** retired updates on the edge leaving the final state. Visible from the first FETCH cycle; wraps from all-ones to 0.

## Structure
- Package mips_ctrl_pkg holds:
  - the opcode localparams
  - the state enum/localparams (4-bit)
  - the ALUOp codes: 00 add, 01 sub, 10 funct, 11 imm
  - the PCSource and ALUSrcB codes
- One natural sub-module, opcode_dispatch: combinational DECODE next-state plus illegal detection, parametrised by ENABLE_IMM/ENABLE_BNE.
- The FSM register, output decode, and counter stay in multicycle_control.

## Test plan
- **Reset held 3 cycles mid-MEMRD:** all strobes 0 during reset; state=0 and retired=0 after; IRWrite only once mem_ready=1.
- **LW (100011), mem_ready=1:** states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 in cycle 5; retired 0→1.
- **SW with mem_ready low 2 cycles in MEMWR:** 6 cycles total. MemWrite=1 for 3 cycles; RegWrite never asserts.
- **Opcodes in turn:**
  - BEQ: 3 cycles; PCWriteCond=1, PCSource=01, BranchNE=0.
  - BNE: same, but BranchNE=1.
  - J: PCWrite=1, PCSource=10.
  - retired advances by 3.
- **ADDI (001000):**
  - ENABLE_IMM=1: IMMEX ALUOp=11, then IMMWB RegWrite=1, RegDst=0.
  - ENABLE_IMM=0: illegal_op pulses in DECODE, no writes, retired unchanged.
- **CNT_W=4:** run 17 R-types; retired reads 1 after wrap. Opcode 111111 gives illegal_op plus a 2-cycle return to FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// and the datapath select codes driven by the controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

endpackage

// File: rtl/opcode_dispatch.sv
// DECODE-state dispatch: picks the next state from the opcode and flags
// opcodes that are undecodable under the current feature set.
module opcode_dispatch
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_IMM = 1'b1,
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic [5:0] opcode_i,
  output state_t     next_state_o,
  output logic       illegal_o
);

  always_comb begin
    next_state_o = S_FETCH;
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_LW, OP_SW: next_state_o = S_MEMADR;
      OP_R:         next_state_o = S_EXEC;
      OP_BEQ:       next_state_o = S_BRANCH;
      OP_J:         next_state_o = S_JUMP;
      OP_BNE: begin
        if (ENABLE_BNE) next_state_o = S_BRANCH;
        else            illegal_o    = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        if (ENABLE_IMM) next_state_o = S_IMMEX;
        else            illegal_o    = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences the shared ALU/memory datapath,
// stalls on mem_ready, and counts retired instructions.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit ENABLE_IMM = 1'b1,
  parameter bit ENABLE_BNE = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t             state_q, state_d, disp_state_s, out_state_s;
  logic               disp_illegal_s, retire_s;
  logic [CNT_W-1:0]   retired_q, retired_d;

  opcode_dispatch #(
    .ENABLE_IMM(ENABLE_IMM),
    .ENABLE_BNE(ENABLE_BNE)
  ) u_dispatch (
    .opcode_i    (opcode),
    .next_state_o(disp_state_s),
    .illegal_o   (disp_illegal_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Final states retire into FETCH; MEMWR only retires once memory accepts.
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = disp_state_s;
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
    retired_d = retire_s ? (retired_q + {{(CNT_W-1){1'b0}}, 1'b1}) : retired_q;
  end

  // While reset is high the outputs show FETCH selects with all strobes low.
  assign out_state_s = reset ? S_FETCH : state_q;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    case (out_state_s)
      S_FETCH: begin
        MemRead = ~reset;
        IRWrite = mem_ready & ~reset;
        PCWrite = mem_ready & ~reset;
        ALUSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_BROFF;
        illegal_op = disp_illegal_s;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        BranchNE    = (opcode == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_IMM;
      end
      S_IMMWB:  RegWrite = 1'b1;
      default:  PCWrite = 1'b0;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver pushes hand-derived expectations per cycle,
// a negedge monitor pops and compares them against the selected DUT.
module tb_multicycle_control;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010,
                         ADDI = 6'b001000, BAD = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, mr_a, rst_b, mr_b;
  logic [5:0] opc_a, opc_b;

  logic pcw_a, pcwc_a, bne_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a, ill_a;
  logic pcw_b, pcwc_b, bne_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b, ill_b;
  logic [1:0] asb_a, aop_a, pcs_a, asb_b, aop_b, pcs_b;
  logic [3:0] st_a, st_b;
  logic [31:0] ret_a;
  logic [3:0]  ret_b;

  multicycle_control dut_a (
    .clk(clk), .reset(rst_a), .opcode(opc_a), .mem_ready(mr_a),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .BranchNE(bne_a), .IorD(iord_a),
    .MemRead(mrd_a), .MemWrite(mwr_a), .IRWrite(irw_a), .MemtoReg(m2r_a),
    .RegDst(rdst_a), .RegWrite(rw_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a),
    .ALUOp(aop_a), .PCSource(pcs_a), .state(st_a), .illegal_op(ill_a),
    .retired(ret_a)
  );

  multicycle_control #(.ENABLE_IMM(1'b0), .ENABLE_BNE(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(opc_b), .mem_ready(mr_b),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .BranchNE(bne_b), .IorD(iord_b),
    .MemRead(mrd_b), .MemWrite(mwr_b), .IRWrite(irw_b), .MemtoReg(m2r_b),
    .RegDst(rdst_b), .RegWrite(rw_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b),
    .ALUOp(aop_b), .PCSource(pcs_b), .state(st_b), .illegal_op(ill_b),
    .retired(ret_b)
  );

  wire [16:0] ctl_a = {pcw_a, pcwc_a, bne_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a,
                       rdst_a, rw_a, asa_a, asb_a, aop_a, pcs_a};
  wire [16:0] ctl_b = {pcw_b, pcwc_b, bne_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b,
                       rdst_b, rw_b, asa_b, asb_b, aop_b, pcs_b};

  typedef struct {
    int          dut;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Expected control bundle straight from the per-state output table.
  function automatic logic [16:0] exp_ctl(logic [3:0] st, logic mr, logic [5:0] opc, logic rst);
    logic pcw = 1'b0, pcwc = 1'b0, bne = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0;
    logic irw = 1'b0, m2r = 1'b0, rdst = 1'b0, rw = 1'b0, asa = 1'b0;
    logic [1:0] asb = 2'b00, aop = 2'b00, pcs = 2'b00;
    if (rst) asb = 2'b01;
    else begin
      case (st)
        4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
        4'd1:  asb = 2'b11;
        4'd2:  begin asa = 1'b1; asb = 2'b10; end
        4'd3:  begin iord = 1'b1; mrd = 1'b1; end
        4'd4:  begin m2r = 1'b1; rw = 1'b1; end
        4'd5:  begin iord = 1'b1; mwr = 1'b1; end
        4'd6:  begin asa = 1'b1; aop = 2'b10; end
        4'd7:  begin rdst = 1'b1; rw = 1'b1; end
        4'd8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; bne = (opc == BNE); end
        4'd9:  begin pcw = 1'b1; pcs = 2'b10; end
        4'd10: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
        4'd11: rw = 1'b1;
        default: ;
      endcase
    end
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  function automatic logic legal(int dut, logic [5:0] opc);
    case (opc)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010: return 1'b1;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return (dut == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string name, int dut, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, dut, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      if (mon_e.dut == 0) begin
        check("state", 0, {28'd0, st_a}, {28'd0, mon_e.st});
        check("ctl", 0, {15'd0, ctl_a}, {15'd0, mon_e.ctl});
        check("illegal_op", 0, {31'd0, ill_a}, {31'd0, mon_e.ill});
        check("retired", 0, ret_a, mon_e.ret);
      end else begin
        check("state", 1, {28'd0, st_b}, {28'd0, mon_e.st});
        check("ctl", 1, {15'd0, ctl_b}, {15'd0, mon_e.ctl});
        check("illegal_op", 1, {31'd0, ill_b}, {31'd0, mon_e.ill});
        check("retired", 1, {28'd0, ret_b}, mon_e.ret);
      end
    end
  end

  task automatic cyc(int dut, logic [5:0] opc, logic mr, logic rst, logic [3:0] st, logic [31:0] ret);
    exp_t e;
    if (dut == 0) begin opc_a = opc; mr_a = mr; rst_a = rst; end
    else          begin opc_b = opc; mr_b = mr; rst_b = rst; end
    e.dut = dut;
    e.st  = st;
    e.ctl = exp_ctl(st, mr, opc, rst);
    e.ill = !rst && (st == 4'd1) && !legal(dut, opc);
    e.ret = ret;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // sts/mrs are listed first-cycle-first (MSB side) for n cycles.
  task automatic instr(int dut, logic [5:0] opc, int n, logic [47:0] sts, logic [11:0] mrs, logic [31:0] ret);
    for (int i = 0; i < n; i++)
      cyc(dut, opc, mrs[n-1-i], 1'b0, sts[4*(n-1-i) +: 4], ret);
  endtask

  initial begin
    rst_a = 1'b1; mr_a = 1'b0; opc_a = R;
    rst_b = 1'b1; mr_b = 1'b0; opc_b = R;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then reset asserted mid-MEMRD.
    cyc(0, R, 1'b0, 1'b1, 4'd0, 0);
    cyc(0, LW, 1'b1, 1'b0, 4'd0, 0);
    cyc(0, LW, 1'b1, 1'b0, 4'd1, 0);
    cyc(0, LW, 1'b1, 1'b0, 4'd2, 0);
    cyc(0, LW, 1'b0, 1'b0, 4'd3, 0);
    cyc(0, LW, 1'b1, 1'b1, 4'd3, 0);
    cyc(0, LW, 1'b1, 1'b1, 4'd0, 0);
    cyc(0, LW, 1'b1, 1'b1, 4'd0, 0);
    cyc(0, LW, 1'b0, 1'b0, 4'd0, 0);

    instr(0, LW,   5, 48'h01234,  12'b11111,  0);
    instr(0, SW,   6, 48'h012555, 12'b111001, 1);
    instr(0, BEQ,  3, 48'h018,    12'b111,    2);
    instr(0, BNE,  3, 48'h018,    12'b111,    3);
    instr(0, J,    3, 48'h019,    12'b111,    4);
    instr(0, R,    4, 48'h0167,   12'b1111,   5);
    instr(0, ADDI, 4, 48'h01AB,   12'b1111,   6);
    instr(0, R,    5, 48'h00167,  12'b01111,  7);
    instr(0, BAD,  2, 48'h01,     12'b11,     8);
    cyc(0, R, 1'b0, 1'b0, 4'd0, 8);
    rst_a = 1'b1;

    // Reduced-feature instance: ADDI illegal, 4-bit counter wraps.
    cyc(1, R, 1'b0, 1'b1, 4'd0, 0);
    instr(1, ADDI, 2, 48'h01, 12'b11, 0);
    for (int i = 0; i < 17; i++)
      instr(1, R, 4, 48'h0167, 12'hF, i % 16);
    instr(1, BAD, 2, 48'h01, 12'b11, 1);
    instr(1, BNE, 3, 48'h018, 12'b111, 1);
    cyc(1, R, 1'b0, 1'b0, 4'd0, 2);

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
